// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async read ports, 2 write ports (port 1 wins), x0 hardwired, clear sequencer.
// Latency: reads combinational, writes one edge; clear takes DEPTH cycles. Optional REGFILE_BYPASS_EN adds write-through.
// Backpressure: none on writes; ready stays low during clear, and writes are dropped until it rises.
module reg_file_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              wr_en,
    input  logic [2*AW-1:0]         wr_addr,
    input  logic [2*WIDTH-1:0]      wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic                    ready,
    output logic                    wr_collision
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;
    logic             we0, we1;

    assign wa0 = wr_addr[0 +: AW];
    assign wa1 = wr_addr[AW +: AW];
    assign wd0 = wr_data[0 +: WIDTH];
    assign wd1 = wr_data[WIDTH +: WIDTH];
    assign we0 = !rst && (state == READY) && wr_en[0] && (wa0 != '0);
    assign we1 = !rst && (state == READY) && wr_en[1] && (wa1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            ready        <= 1'b0;
            wr_collision <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_collision <= 1'b0;
                    // Stop on the last entry so cnt never wraps.
                    if (cnt == LAST) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    wr_collision <= we0 && we1 && (wa0 == wa1);
                end
            endcase
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (we0) mem[wa0] <= wd0;
            if (we1) mem[wa1] <= wd1;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] lane;

        assign ra = rd_addr[r*AW +: AW];

        always_comb begin
            lane = '0;
            if (state == READY && ra != '0) begin
                lane = mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (we0 && wa0 == ra) lane = wd0;
                if (we1 && wa1 == ra) lane = wd1;
`endif
            end
        end

        assign rd_data[r*WIDTH +: WIDTH] = lane;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against a behavioural array model.
module tb_reg_file_mp;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NUM_RD = 2;
    localparam int AW = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              wr_en;
    logic [2*AW-1:0]         wr_addr;
    logic [2*WIDTH-1:0]      wr_data;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic                    ready;
    logic                    wr_collision;

    reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready), .wr_collision(wr_collision)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain array plus a countdown for the clear phase.
    logic [WIDTH-1:0] model [DEPTH];
    bit               m_ready = 0;
    int               clr_left = 0;
    bit               exp_coll = 0;
    bit               checks_on = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_read(input logic r, input logic [1:0] en,
            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
            input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        if (!m_ready || ra == 0) return '0;
        v = model[ra];
`ifdef REGFILE_BYPASS_EN
        if (!r && en[0] && a0 == ra) v = d0;
        if (!r && en[1] && a1 == ra) v = d1;
`else
        if (r && en[0] && a0 == ra && d0 == d1 && a1 == ra) v = model[ra];
`endif
        return v;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, update the model.
    task automatic cyc(input logic r, input logic [1:0] en,
            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
            input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
            input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        bit nc;
        rst = r; wr_en = en;
        wr_addr = {a1, a0}; wr_data = {d1, d0}; rd_addr = {r1, r0};
        #1;
        if (checks_on) begin
            check("rd_lane0", rd_data[0 +: WIDTH], exp_read(r, en, a0, a1, d0, d1, r0));
            check("rd_lane1", rd_data[WIDTH +: WIDTH], exp_read(r, en, a0, a1, d0, d1, r1));
            check("ready", {31'b0, ready}, {31'b0, m_ready});
            check("wr_collision", {31'b0, wr_collision}, {31'b0, exp_coll});
        end
        @(posedge clk);
        nc = !r && m_ready && en == 2'b11 && a0 == a1 && a0 != 0;
        if (r) begin
            m_ready = 0;
            clr_left = DEPTH;
        end else if (!m_ready) begin
            clr_left--;
            if (clr_left == 0) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end
        end else begin
            if (en[0] && a0 != 0) model[a0] = d0;
            if (en[1] && a1 != 0) model[a1] = d1;
        end
        exp_coll = nc;
        checks_on = 1;
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        cyc(1'b0, 2'b00, '0, '0, '0, '0, r0, r1);
    endtask

    int n;

    initial begin
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(negedge clk);
        cyc(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);

        // Clear length; writes attempted during clear must be dropped.
        n = 0;
        while (!ready && n < 100) begin
            cyc(1'b0, 2'b01, 5, 0, 32'hAAAA_AAAA, 0, 5, 0);
            n++;
        end
        check("clear_len", n, DEPTH);
        for (int i = 0; i < DEPTH; i += 2) idle(AW'(i), AW'(i + 1));
        check("addr5_after_clear", rd_data[0 +: WIDTH] | 32'h0, model[5]);

        // Dual write, distinct addresses.
        cyc(1'b0, 2'b11, 3, 7, 32'h1111_1111, 32'h2222_2222, 3, 7);
        idle(3, 7);
        check("dual_rd3", rd_data[0 +: WIDTH], 32'h1111_1111);

        // Collision on address 9.
        cyc(1'b0, 2'b11, 9, 9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 9, 9);
        idle(9, 9);
        check("coll_rd9", rd_data[WIDTH +: WIDTH], 32'hCAFE_F00D);
        idle(9, 9);

        // x0 writes, including both ports on address 0.
        cyc(1'b0, 2'b10, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        cyc(1'b0, 2'b11, 0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
        idle(0, 0);

        // Same-cycle read of a write target.
        cyc(1'b0, 2'b01, 12, 0, 32'h0000_00C3, 0, 12, 12);
        idle(12, 0);
        check("byp_next_rd12", rd_data[0 +: WIDTH], 32'h0000_00C3);

        // Reset ten cycles into a clear.
        cyc(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) idle(12, 3);
        cyc(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (!ready && n < 100) begin
            idle(12, 3);
            n++;
        end
        check("midclear_len", n, DEPTH);

        // Random traffic over a narrow address range so collisions occur.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)),
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                $urandom, $urandom,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
